// File: rtl/delta_pkg.sv
// Shared definitions for the streaming delta decoder: output-register state
// encoding, default widths and two's-complement range helpers.
// Optional build macro: DELTA_DECODER_SATURATE_EN (used by sat_add / delta_decoder).
package delta_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEFAULT_DATAWIDTH = 10;
    localparam int DEFAULT_CNTWIDTH  = 8;

    // Largest positive value representable in a signed field of the given width.
    function automatic longint signed_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    // Most negative value representable in a signed field of the given width.
    function automatic longint signed_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational two's-complement adder for the decoder accumulator.
// Optional build macro: DELTA_DECODER_SATURATE_EN -- when defined the sum clamps
// to the signed range and sat flags the clamp; otherwise the sum wraps and sat=0.
module sat_add
    import delta_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 sat
);

`ifdef DELTA_DECODER_SATURATE_EN
    localparam logic [DATAWIDTH-1:0] SAT_MAX = DATAWIDTH'(signed_max(DATAWIDTH));
    localparam logic [DATAWIDTH-1:0] SAT_MIN = DATAWIDTH'(signed_min(DATAWIDTH));

    logic [DATAWIDTH:0] wide;

    // Sign-extended add; the two top bits disagree exactly on signed overflow.
    always_comb begin
        wide = {a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b};
        sat  = wide[DATAWIDTH] ^ wide[DATAWIDTH-1];
        if (!sat) begin
            sum = wide[DATAWIDTH-1:0];
        end else if (wide[DATAWIDTH]) begin
            sum = SAT_MIN;
        end else begin
            sum = SAT_MAX;
        end
    end
`else
    // Plain modulo-2^DATAWIDTH add; never flags a clamp.
    assign sum = a + b;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/delta_decoder.sv
// Streaming delta decoder: accumulates signed differences (or reseeds on
// in_load) and presents each reconstructed sample on a one-deep registered
// valid/ready output stage that sustains one sample per cycle.
// Optional build macro: DELTA_DECODER_SATURATE_EN (saturating accumulate, out_sat).
module delta_decoder
    import delta_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int CNTWIDTH  = DEFAULT_CNTWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_diff,
    input  logic                 in_load,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_sample,
    output logic [CNTWIDTH-1:0]  out_count,
    output logic                 out_sat
);

    state_t                state_reg;
    state_t                state_next;
    logic [DATAWIDTH-1:0]  acc_reg;
    logic [DATAWIDTH-1:0]  sample_reg;
    logic [CNTWIDTH-1:0]   count_reg;
    logic                  sat_reg;

    logic                  accept;
    logic [DATAWIDTH-1:0]  add_sum;
    logic                  add_sat;
    logic [DATAWIDTH-1:0]  value_next;
    logic                  sat_next;
    logic [CNTWIDTH-1:0]   count_next;

    // The output stage can take new data when empty or when it is draining
    // this same cycle; the combinational path from out_ready is deliberate.
    assign out_valid = (state_reg == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_sample = sample_reg;
    assign out_count  = count_reg;
    assign out_sat    = sat_reg;

    sat_add #(
        .DATAWIDTH (DATAWIDTH)
    ) u_sat_add (
        .a   (acc_reg),
        .b   (in_diff),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Next sample/flag/count; a load reseeds, never clamps, and restarts the count.
    always_comb begin
        value_next = add_sum;
        sat_next   = add_sat;
        count_next = (count_reg == '1) ? count_reg : count_reg + 1'b1;
        if (in_load) begin
            value_next = in_diff;
            sat_next   = 1'b0;
            count_next = '0;
        end
    end

    // Output-stage FSM next state: fill on accept, drain on handshake alone.
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = FULL;
        end else if (out_valid && out_ready) begin
            state_next = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accumulator and output data registers; only an accept changes them.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_reg    <= '0;
            sample_reg <= '0;
            count_reg  <= '0;
            sat_reg    <= 1'b0;
        end else if (accept) begin
            acc_reg    <= value_next;
            sample_reg <= value_next;
            count_reg  <= count_next;
            sat_reg    <= sat_next;
        end
    end

endmodule

// File: tb/tb_delta_decoder.sv
// Directed, table-driven bench for delta_decoder, plus hand-written sequences
// for asynchronous mid-stream reset and count saturation (second instance
// with CNTWIDTH=2). Expected values follow DELTA_DECODER_SATURATE_EN if defined.
module tb_delta_decoder;

    localparam int DW  = 10;
    localparam int CW  = 8;
    localparam int CW2 = 2;

`ifdef DELTA_DECODER_SATURATE_EN
    localparam logic [DW-1:0] HI_SAMPLE = 10'h1FF;
    localparam logic          HI_SAT    = 1'b1;
    localparam logic [DW-1:0] LO_SAMPLE = 10'h200;
    localparam logic          LO_SAT    = 1'b1;
`else
    localparam logic [DW-1:0] HI_SAMPLE = 10'h200;
    localparam logic          HI_SAT    = 1'b0;
    localparam logic [DW-1:0] LO_SAMPLE = 10'h1FF;
    localparam logic          LO_SAT    = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_load, out_valid, out_ready, out_sat;
    logic [DW-1:0] in_diff, out_sample;
    logic [CW-1:0] out_count;

    logic           in_valid2, in_ready2, in_load2, out_valid2, out_ready2, out_sat2;
    logic [DW-1:0]  in_diff2, out_sample2;
    logic [CW2-1:0] out_count2;

    delta_decoder #(.DATAWIDTH(DW), .CNTWIDTH(CW)) u_dut (
        .Clk        (clk),
        .Rst        (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_diff    (in_diff),
        .in_load    (in_load),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_count  (out_count),
        .out_sat    (out_sat)
    );

    delta_decoder #(.DATAWIDTH(DW), .CNTWIDTH(CW2)) u_dut_cnt2 (
        .Clk        (clk),
        .Rst        (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_diff    (in_diff2),
        .in_load    (in_load2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_sample (out_sample2),
        .out_count  (out_count2),
        .out_sat    (out_sat2)
    );

    typedef struct {
        logic          v;
        logic          ld;
        logic [DW-1:0] d;
        logic          rdy;
        logic          exp_ir;
        logic          exp_ov;
        logic [DW-1:0] exp_s;
        logic [CW-1:0] exp_c;
        logic          exp_sat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic v, input logic ld, input logic [DW-1:0] d,
                                    input logic rdy, input logic exp_ir, input logic exp_ov,
                                    input logic [DW-1:0] exp_s, input logic [CW-1:0] exp_c,
                                    input logic exp_sat);
        vec_t t;
        t.v = v; t.ld = ld; t.d = d; t.rdy = rdy;
        t.exp_ir = exp_ir; t.exp_ov = exp_ov; t.exp_s = exp_s;
        t.exp_c = exp_c; t.exp_sat = exp_sat;
        vecs.push_back(t);
    endfunction

    // Drive one cycle of inputs, check in_ready before the edge and the
    // registered outputs just after it.
    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        in_valid  = t.v;
        in_load   = t.ld;
        in_diff   = t.d;
        out_ready = t.rdy;
        #1;
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(t.exp_ir));
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(t.exp_ov));
        check($sformatf("v%0d out_sample", idx), 32'(out_sample), 32'(t.exp_s));
        check($sformatf("v%0d out_count", idx), 32'(out_count), 32'(t.exp_c));
        check($sformatf("v%0d out_sat", idx), 32'(out_sat), 32'(t.exp_sat));
        $display("vec %0d: v=%0b ld=%0b d=%03h rdy=%0b -> ov=%0b s=%03h c=%0d sat=%0b",
                 idx, t.v, t.ld, t.d, t.rdy, out_valid, out_sample, out_count, out_sat);
    endtask

    initial begin
        vec_t t;

        //      v  ld d        rdy ir ov sample     cnt sat
        add_vec(1, 0, 10'd5,   1,  1, 1, 10'd5,     1,  0);
        add_vec(1, 0, 10'd3,   1,  1, 1, 10'd8,     2,  0);
        add_vec(1, 0, 10'h3FE, 1,  1, 1, 10'd6,     3,  0);  // -2
        add_vec(1, 1, 10'd100, 1,  1, 1, 10'd100,   0,  0);
        add_vec(1, 0, 10'h3FF, 1,  1, 1, 10'd99,    1,  0);  // -1
        add_vec(0, 0, 10'd0,   1,  1, 0, 10'd99,    1,  0);  // drain, sample holds
        add_vec(1, 1, 10'd10,  0,  1, 1, 10'd10,    0,  0);  // acc 10, pending
        add_vec(1, 0, 10'd7,   0,  0, 1, 10'd10,    0,  0);  // stall x4
        add_vec(1, 0, 10'd7,   0,  0, 1, 10'd10,    0,  0);
        add_vec(1, 0, 10'd7,   0,  0, 1, 10'd10,    0,  0);
        add_vec(1, 0, 10'd7,   0,  0, 1, 10'd10,    0,  0);
        add_vec(1, 0, 10'd7,   1,  1, 1, 10'd17,    1,  0);  // release
        add_vec(0, 0, 10'd0,   1,  1, 0, 10'd17,    1,  0);  // no duplicate
        add_vec(0, 1, 10'd300, 1,  1, 0, 10'd17,    1,  0);  // load without valid
        add_vec(1, 0, 10'd1,   1,  1, 1, 10'd18,    2,  0);  // acc kept at 17
        add_vec(1, 1, 10'h1FF, 1,  1, 1, 10'h1FF,   0,  0);  // load 511
        add_vec(1, 0, 10'd1,   1,  1, 1, HI_SAMPLE, 1,  HI_SAT);
        add_vec(1, 1, 10'h200, 1,  1, 1, 10'h200,   0,  0);  // load -512
        add_vec(1, 0, 10'h3FF, 1,  1, 1, LO_SAMPLE, 1,  LO_SAT);

        rst_n      = 1'b0;
        in_valid   = 1'b0; in_load  = 1'b0; in_diff  = '0; out_ready  = 1'b0;
        in_valid2  = 1'b0; in_load2 = 1'b0; in_diff2 = '0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_sample", 32'(out_sample), 32'd0);
        check("reset out_count", 32'(out_count), 32'd0);
        check("reset out_sat", 32'(out_sat), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            t = vecs[i];
            apply(t, i);
        end

        // Asynchronous reset while a sample is pending and stalled.
        @(negedge clk);
        in_valid = 1'b1; in_load = 1'b0; in_diff = 10'd9; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_sample", 32'(out_sample), 32'd0);
        check("async reset out_count", 32'(out_count), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        $display("async reset: ov=%0b s=%03h c=%0d", out_valid, out_sample, out_count);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        t = '{v: 1'b1, ld: 1'b0, d: 10'd4, rdy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1,
              exp_s: 10'd4, exp_c: 8'd1, exp_sat: 1'b0};
        apply(t, 100);

        // Count saturation on the CNTWIDTH=2 instance.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid2 = 1'b1; in_load2 = 1'b0; in_diff2 = 10'd1; out_ready2 = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("cnt2 #%0d out_sample", k), 32'(out_sample2), 32'(k + 1));
            check($sformatf("cnt2 #%0d out_count", k), 32'(out_count2),
                  32'((k + 1 > 3) ? 3 : k + 1));
            check($sformatf("cnt2 #%0d out_valid", k), 32'(out_valid2), 32'd1);
            $display("cnt2 %0d: s=%0d c=%0d", k, out_sample2, out_count2);
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
